ysyx_24110006_lsu: RTL and testbench
====================================

YSYX_24110006_LSU -- requirements
Module: ysyx_24110006_lsu

Interface
REQ-001 The block SHALL have these ports:
- i_clock  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_valid  in  1  one-cycle pulse from the execute stage; the request fields below are valid in that cycle.
- i_mem_ren  in  1  load request.
- i_mem_wen  in  1  store request.
- i_mem_wmask  in  4  store size mask: 0001 byte, 0011 half, 1111 word.
- i_mem_read_t  in  3  load type (funct3): 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- i_mem_addr  in  32  byte address.
- i_wdata  in  32  store data, LSB-aligned.
- i_result  in  32  execute result, passed through for non-memory ops.
- o_valid  out  1  one-cycle completion pulse to writeback.
- o_rdata  out  32  writeback value.
- o_fault  out  1  misaligned or bus error; valid only with o_valid.
- o_busy  out  1  high in any state other than IDLE.
- o_bus_req  out  1  bus request, held until ack.
- o_bus_wen  out  1  1 = write, 0 = read.
- o_bus_addr  out  32  captured i_mem_addr, unmodified.
- o_bus_wdata  out  32  store data shifted left by 8*addr[1:0].
- o_bus_wstrb  out  4  i_mem_wmask shifted left by addr[1:0]; 0000 on reads.
- i_bus_ack  in  1  transfer complete; rdata/err valid this cycle.
- i_bus_rdata  in  32  read word.
- i_bus_err  in  1  bus error, qualified by i_bus_ack.

Function
REQ-002 The state machine SHALL have three states: IDLE, REQ, DONE.
REQ-003 In IDLE, i_valid=1 SHALL capture all request fields. The next state SHALL be REQ if (ren|wen) and the access is aligned; otherwise DONE.
REQ-004 i_valid SHALL be ignored outside IDLE; captured fields SHALL hold until the return to IDLE.
REQ-005 If ren and wen are both 1, the access SHALL be treated as a store.
REQ-006 Misalignment is defined as:
- half access (lh, lhu, or wmask 0011) with addr[0]=1;
- word access (lw, or wmask 1111) with addr[1:0]!=00.
A misaligned access SHALL skip REQ and go to DONE with o_fault=1 and o_rdata=0.
REQ-007 In REQ, o_bus_req SHALL be 1 with address, wen, wdata and wstrb stable every cycle until i_bus_ack=1.
REQ-008 On the ack cycle, the block SHALL latch i_bus_rdata and i_bus_err and move to DONE. o_bus_req SHALL be 0 in the following cycle.
REQ-009 i_bus_ack while not in REQ SHALL be ignored.
REQ-010 DONE SHALL assert o_valid for exactly one cycle, then return to IDLE. A new i_valid can be accepted in the IDLE cycle that follows.
REQ-011 Latency:
- non-memory op: i_valid at cycle T gives o_valid at T+1;
- memory op: ack at cycle A (A>=T+1) gives o_valid at A+1.
REQ-012 Non-memory op: o_rdata SHALL equal the captured i_result and o_fault SHALL be 0.
REQ-013 Load: word w = rdata >> 8*addr[1:0].
- lb / lh: sign-extend w[7:0] / w[15:0];
- lbu / lhu: zero-extend;
- lw, or any other read_t: w unchanged.
REQ-014 Store: o_rdata SHALL be 0. o_fault SHALL equal the latched i_bus_err.
REQ-015 Load with i_bus_err=1: o_rdata SHALL be 0 and o_fault SHALL be 1.
REQ-016 o_rdata and o_fault SHALL be registered and stable during o_valid.

Reset
REQ-017 When i_reset=1, the block SHALL go to IDLE.
REQ-018 Reset values SHALL be 0 for o_valid, o_rdata, o_fault, o_busy, o_bus_req, o_bus_wen and o_bus_wstrb.
REQ-019 Reset during REQ SHALL drop o_bus_req from the next cycle. A later ack for the abandoned transfer SHALL be ignored, and no o_valid SHALL be produced for it.
REQ-020 i_valid coincident with i_reset SHALL be discarded.

Verification
REQ-021 Pass-through: i_valid with ren=wen=0, i_result=0x1234_5678 -> o_valid at T+1 with o_rdata=0x1234_5678, o_fault=0, no o_bus_req.
REQ-022 Signed byte load: lb at addr 0x8000_0003; bus acks 2 cycles after req with rdata 0x80AA_BBCC -> bus_addr=0x8000_0003, wstrb=0000; o_rdata=0xFFFF_FF80 one cycle after ack.
REQ-023 Unsigned half load: lhu at addr 0x8000_0002, rdata 0xF00D_1234 -> o_rdata=0x0000_F00D.
REQ-024 Half store: store wmask 0011, addr 0x8000_0102, wdata 0x0000_ABCD -> wstrb=1100, wdata=0xABCD_0000, req held until ack; o_valid next cycle, o_fault=0.
REQ-025 Misaligned load: lw at 0x8000_0001 -> no bus_req, o_valid at T+1 with o_fault=1, o_rdata=0.
REQ-026 Error and reset: load acked with err=1 -> o_fault=1, o_rdata=0. Separately, reset asserted in REQ, then ack -> o_bus_req low after reset, and no o_valid.

Source files
------------

// File: rtl/ysyx_24110006_lsu.sv
// ysyx_24110006_lsu: load/store unit; captures one request, runs at most one bus transfer,
// and returns a registered, formatted writeback value with a fault flag.
module ysyx_24110006_lsu (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [3:0]  i_mem_wmask,
    input  logic [2:0]  i_mem_read_t,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_result,
    output logic        o_valid,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_busy,
    output logic        o_bus_req,
    output logic        o_bus_wen,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wstrb,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t r_state, w_next;
    logic        r_wen;
    logic [3:0]  r_wmask;
    logic [2:0]  r_read_t;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        r_fault;
    logic        w_mem, w_half, w_word, w_misal;
    logic [31:0] w_sh, w_load;
    // a store wins when ren and wen are both set, so size comes from wmask then
    assign w_mem   = i_mem_ren | i_mem_wen;
    assign w_half  = i_mem_wen ? (i_mem_wmask == 4'b0011) : (i_mem_read_t == 3'b001 || i_mem_read_t == 3'b101);
    assign w_word  = i_mem_wen ? (i_mem_wmask == 4'b1111) : (i_mem_read_t == 3'b010);
    assign w_misal = w_mem & ((w_half & i_mem_addr[0]) | (w_word & |i_mem_addr[1:0]));
    assign w_sh    = i_bus_rdata >> {r_addr[1:0], 3'b000};
    assign w_load  = r_read_t == 3'b000 ? {{24{w_sh[7]}}, w_sh[7:0]} :
                     r_read_t == 3'b001 ? {{16{w_sh[15]}}, w_sh[15:0]} :
                     r_read_t == 3'b100 ? {24'd0, w_sh[7:0]} :
                     r_read_t == 3'b101 ? {16'd0, w_sh[15:0]} : w_sh;
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_valid) w_next = (w_mem && !w_misal) ? REQ : DONE;
            REQ:     if (i_bus_ack) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wen    <= 1'b0;
            r_wmask  <= 4'd0;
            r_read_t <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_fault  <= 1'b0;
        end else if (r_state == IDLE && i_valid) begin
            r_wen    <= i_mem_wen;
            r_wmask  <= i_mem_wmask;
            r_read_t <= i_mem_read_t;
            r_addr   <= i_mem_addr;
            r_wdata  <= i_wdata;
            r_rdata  <= w_mem ? 32'd0 : i_result;
            r_fault  <= w_misal;
        end else if (r_state == REQ && i_bus_ack) begin
            r_rdata  <= (r_wen || i_bus_err) ? 32'd0 : w_load;
            r_fault  <= i_bus_err;
        end
    end
    assign o_valid     = r_state == DONE;
    assign o_busy      = r_state != IDLE;
    assign o_bus_req   = r_state == REQ;
    assign o_rdata     = r_rdata;
    assign o_fault     = r_fault;
    assign o_bus_wen   = r_wen;
    assign o_bus_addr  = r_addr;
    assign o_bus_wdata = r_wdata << {r_addr[1:0], 3'b000};
    assign o_bus_wstrb = r_wen ? r_wmask << r_addr[1:0] : 4'b0000;
endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// tb_ysyx_24110006_lsu: directed and randomized transactions against an arithmetic reference model.
module tb_ysyx_24110006_lsu;
    logic        clk = 1'b0;
    logic        rst, valid, ren, wen, ack, err;
    logic [3:0]  wmask;
    logic [2:0]  read_t;
    logic [31:0] addr, wdata, result, bus_rdata;
    logic        o_valid, o_fault, o_busy, o_bus_req, o_bus_wen;
    logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_wstrb;
    int n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    ysyx_24110006_lsu dut (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_mem_ren(ren), .i_mem_wen(wen),
        .i_mem_wmask(wmask), .i_mem_read_t(read_t), .i_mem_addr(addr), .i_wdata(wdata),
        .i_result(result), .o_valid(o_valid), .o_rdata(o_rdata), .o_fault(o_fault),
        .o_busy(o_busy), .o_bus_req(o_bus_req), .o_bus_wen(o_bus_wen), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .o_bus_wstrb(o_bus_wstrb), .i_bus_ack(ack),
        .i_bus_rdata(bus_rdata), .i_bus_err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int access_size(input bit w, input logic [3:0] m, input logic [2:0] t);
        if (w) return m == 4'b1111 ? 4 : m == 4'b0011 ? 2 : 1;
        return t == 3'd2 ? 4 : (t == 3'd1 || t == 3'd5) ? 2 : 1;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
        longint w, v;
        w = longint'(rd) / (longint'(1) << (8 * (a % 4)));
        case (t)
            3'd0: begin v = w % 256; if (v >= 128) v -= 256; end
            3'd1: begin v = w % 65536; if (v >= 32768) v -= 65536; end
            3'd4: v = w % 256;
            3'd5: v = w % 65536;
            default: v = w;
        endcase
        return v[31:0];
    endfunction

    task automatic run(input bit r, input bit w, input logic [3:0] m, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] res,
                       input logic [31:0] rd, input bit e, input int lat);
        bit mem, mis;
        logic [31:0] exp_d, exp_strb;
        bit exp_f;
        mem = r | w;
        mis = mem && (a % access_size(w, m, t)) != 0;
        if (!mem) begin exp_d = res; exp_f = 0; end
        else if (mis) begin exp_d = 0; exp_f = 1; end
        else if (w) begin exp_d = 0; exp_f = e; end
        else if (e) begin exp_d = 0; exp_f = 1; end
        else begin exp_d = load_value(t, a, rd); exp_f = 0; end
        exp_strb = w ? ((32'(m) << (a % 4)) & 32'hF) : 32'h0;
        @(negedge clk);
        valid = 1; ren = r; wen = w; wmask = m; read_t = t; addr = a; wdata = wd; result = res;
        ack = !(mem && !mis) && $urandom_range(0, 1) == 1;
        err = 1;
        @(negedge clk);
        valid = 0; ack = 0; err = 0;
        if (mem && !mis) begin
            check("bus_req", 32'(o_bus_req), 1);
            check("bus_addr", o_bus_addr, a);
            check("bus_wen", 32'(o_bus_wen), 32'(w));
            check("bus_wstrb", 32'(o_bus_wstrb), exp_strb);
            check("bus_wdata", o_bus_wdata, wd << (8 * (a % 4)));
            check("valid_early", 32'(o_valid), 0);
            for (int k = 1; k < lat; k++) begin
                valid = 1; ren = $urandom; wen = $urandom; addr = $urandom; wmask = $urandom; wdata = $urandom;
                @(negedge clk);
                check("req_held", 32'(o_bus_req), 1);
                check("addr_held", o_bus_addr, a);
                check("wstrb_held", 32'(o_bus_wstrb), exp_strb);
                check("valid_wait", 32'(o_valid), 0);
            end
            valid = 0; ack = 1; bus_rdata = rd; err = e;
            @(negedge clk);
            ack = 0; err = 0; bus_rdata = $urandom;
        end
        check("valid", 32'(o_valid), 1);
        check("req_done", 32'(o_bus_req), 0);
        check("rdata", o_rdata, exp_d);
        check("fault", 32'(o_fault), 32'(exp_f));
        @(negedge clk);
        check("valid_once", 32'(o_valid), 0);
        check("busy_idle", 32'(o_busy), 0);
    endtask

    initial begin
        rst = 1; valid = 0; ren = 0; wen = 0; ack = 0; err = 0; wmask = 0; read_t = 0;
        addr = 0; wdata = 0; result = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_fault", 32'(o_fault), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_req", 32'(o_bus_req), 0);
        check("rst_wen", 32'(o_bus_wen), 0);
        check("rst_wstrb", 32'(o_bus_wstrb), 0);
        rst = 0;
        run(0, 0, 4'h0, 3'd0, 32'h8000_0000, 32'h0, 32'h1234_5678, 32'h0, 0, 1);
        run(1, 0, 4'h0, 3'd0, 32'h8000_0003, 32'h0, 32'h0, 32'h80AA_BBCC, 0, 2);
        run(1, 0, 4'h0, 3'd5, 32'h8000_0002, 32'h0, 32'h0, 32'hF00D_1234, 0, 1);
        run(0, 1, 4'h3, 3'd0, 32'h8000_0102, 32'h0000_ABCD, 32'h0, 32'h0, 0, 3);
        run(1, 0, 4'h0, 3'd2, 32'h8000_0001, 32'h0, 32'h0, 32'h0, 0, 1);
        run(1, 0, 4'h0, 3'd2, 32'h8000_0004, 32'h0, 32'h0, 32'hDEAD_BEEF, 1, 2);
        run(1, 1, 4'hF, 3'd2, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 32'h0, 1, 1);
        // abandon a transfer with reset, then ack it late
        @(negedge clk);
        valid = 1; ren = 1; wen = 0; read_t = 3'd2; addr = 32'h8000_0010;
        @(negedge clk);
        valid = 0;
        check("rst_req_pre", 32'(o_bus_req), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst_req_drop", 32'(o_bus_req), 0);
        check("rst_busy_drop", 32'(o_busy), 0);
        ack = 1; bus_rdata = 32'h1111_1111;
        @(negedge clk);
        ack = 0;
        check("late_ack_valid", 32'(o_valid), 0);
        @(negedge clk);
        check("late_ack_valid2", 32'(o_valid), 0);
        // request during reset is dropped
        rst = 1; valid = 1; ren = 0; wen = 0; result = 32'h5555_AAAA;
        @(negedge clk);
        rst = 0; valid = 0;
        check("rst_valid_drop", 32'(o_valid), 0);
        check("rst_valid_busy", 32'(o_busy), 0);
        @(negedge clk);
        check("rst_valid_drop2", 32'(o_valid), 0);
        for (int i = 0; i < 300; i++) begin
            logic [3:0] m;
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            m = sel == 0 ? 4'h1 : sel == 1 ? 4'h3 : sel == 2 ? 4'hF : 4'($urandom);
            run(1'($urandom), $urandom_range(0, 3) == 0, m, 3'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 5) == 0,
                $urandom_range(1, 4));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
